stream_demux_1t2: RTL
=====================

# stream_demux_1t2

Registered 1-to-2 stream demultiplexer for the CARP datapath. It accepts one 32-bit valid/ready input stream and routes each beat to output port 0 or 1 according to a select bit sampled with the beat. Each output has a private 2-entry buffer, so a stalled output does not block beats bound for the other port. It sits on the response side of a shared resource, for example when splitting load data between the register-file writeback path and the CSR path, and performs the inverse of a 2:1 select.

## Interface
- WIDTH, 32: data width of input and both outputs.
- CNT_W, 16: width of the per-port delivered-beat counters.

- CLK  in  1  single clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- IN_VALID  in  1  input beat present.
- IN_SEL  in  1  destination of the current beat: 0 selects OUT0, 1 selects OUT1.
- IN_DATA  in  WIDTH  input beat payload.
- IN_READY  out  1  the beat is accepted when IN_VALID and IN_READY are both high.
- OUT0_VALID / OUT1_VALID  out  1  head of the port buffer is valid.
- OUT0_DATA / OUT1_DATA  out  WIDTH  head of the port buffer.
- OUT0_READY / OUT1_READY  in  1  sink accepts the head.
- CLR_CNT  in  1  synchronous clear of both counters.
- CNT0 / CNT1  out  CNT_W  number of beats delivered on each port.

## Operation
- Accept: IN_READY = !full[IN_SEL]. The path from IN_SEL to IN_READY is combinational. IN_READY does not depend on OUTx_READY, so there is no bypass.
- On accept, IN_DATA is written into buffer[IN_SEL]. The other buffer is untouched.
- Each buffer is a 2-entry FIFO:
  - Fill states: EMPTY, ONE, FULL.
  - Push only: EMPTY→ONE, ONE→FULL.
  - Pop only: FULL→ONE, ONE→EMPTY.
  - Push and pop in the same cycle in ONE: stays ONE.
  - FULL: push is impossible because IN_READY is low.
- Pop: OUTx_VALID && OUTx_READY. OUTx_DATA shows the oldest entry.
- Order is preserved per port. There is no ordering guarantee between the two ports.
- Counters:
  - CNTx increments by 1 on each pop of port x and wraps from 2^CNT_W−1 to 0.
  - CLR_CNT forces both counters to 0. It takes priority over an increment in the same cycle.
- Protocol rules:
  - OUTx_DATA is held stable while OUTx_VALID is high and not popped.
  - OUTx_VALID never drops without a pop.
  - Changes on IN_SEL or IN_DATA while IN_VALID is low have no effect.

## Timing
- Latency: a beat accepted at edge N is visible on OUTx at N+1. OUTx_VALID rises in the cycle after the accept.
- Throughput: 1 beat/cycle per port while the sink holds ready high. The port alternates ONE with push and pop each cycle.
- Reset (RST_N low, at any time, including mid-transfer):
  - Both buffers go EMPTY and buffered beats are discarded.
  - OUT0_VALID = OUT1_VALID = 0.
  - OUT0_DATA = OUT1_DATA = 0.
  - CNT0 = CNT1 = 0.
  - IN_READY = 1 for either IN_SEL, since both buffers are empty.
- After RST_N deasserts, the first accept is possible on the first rising edge.
- Simultaneous events:
  - A pop on one port and a push to the other port in the same cycle are independent.
  - A pop from a FULL buffer frees one slot. IN_READY for that port rises in the next cycle.

## Structure
- Shared package carp_bus_pkg holds:
  - the default data width constant (32);
  - the counter width constant (16);
  - the port index enum (PORT0 = 1'b0, PORT1 = 1'b1);
  - the buffer fill-state enum (EMPTY, ONE, FULL).
- Sub-module demux_slot_buf is the 2-entry FIFO. It has push, push_data, pop, full, valid and head ports, and is instantiated once per output port.
- The top level holds the select decode, the IN_READY mux and the two counters.

## Test plan
- Single routing:
  - Beat 0xDEADBEEF with IN_SEL=1 → OUT1_VALID high one cycle later with OUT1_DATA=0xDEADBEEF.
  - OUT0_VALID stays 0.
  - After the pop, CNT1=1.
- Back-pressure:
  - Hold OUT0_READY=0 and send 0x11, then 0x22 to port 0.
  - IN_READY goes low for IN_SEL=0 and stays high for IN_SEL=1.
  - 0x33 sent to port 1 still reaches OUT1.
  - Releasing OUT0_READY delivers 0x11, then 0x22, in order.
- Streaming:
  - 100 consecutive beats to port 0 with OUT0_READY=1 → IN_READY stays high throughout.
  - Data comes out in order and CNT0=100.
- Reset mid-operation:
  - With both buffers FULL, pulse RST_N low between clock edges.
  - Immediately both VALIDs=0, both DATA=0, both CNT=0 and IN_READY=1.
- Counters:
  - Preload by delivering 65535 beats on port 1, then one more beat → CNT1 wraps to 0.
  - CLR_CNT asserted together with a pop → counter reads 0, not 1.

Source files
------------

// File: rtl/carp_bus_pkg.sv
// Shared CARP bus types and default widths.
// Imported by the demux top level and its per-port slot buffer.
package carp_bus_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_CNT_W  = 16;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_e;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } fill_e;

  function automatic logic [1:0] port_onehot(input port_e p);
    port_onehot = (p == PORT1) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/demux_slot_buf.sv
// Two-entry in-order FIFO holding beats for one demux output port.
// The head entry always sits in e0 so the output data is a plain register.
module demux_slot_buf
  import carp_bus_pkg::*;
#(
  parameter int WIDTH = DEF_DATA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             valid,
  output logic [WIDTH-1:0] head
);

  fill_e            state_q;
  fill_e            state_d;
  logic [WIDTH-1:0] e0_q;
  logic [WIDTH-1:0] e0_d;
  logic [WIDTH-1:0] e1_q;
  logic [WIDTH-1:0] e1_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (state_q == FULL);
  assign valid   = (state_q != EMPTY);
  assign head    = e0_q;
  assign do_push = push && !full;
  assign do_pop  = pop && valid;

  always_comb begin
    state_d = state_q;
    e0_d    = e0_q;
    e1_d    = e1_q;
    case (state_q)
      EMPTY: begin
        if (do_push) begin
          state_d = ONE;
          e0_d    = push_data;
        end
      end
      ONE: begin
        if (do_push && do_pop) begin
          e0_d = push_data;
        end else if (do_push) begin
          state_d = FULL;
          e1_d    = push_data;
        end else if (do_pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // second entry shifts forward to become the head
        if (do_pop) begin
          state_d = ONE;
          e0_d    = e1_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      e0_q    <= '0;
      e1_q    <= '0;
    end else begin
      state_q <= state_d;
      e0_q    <= e0_d;
      e1_q    <= e1_d;
    end
  end

endmodule

// File: rtl/stream_demux_1t2.sv
// Registered 1-to-2 stream demux with a private 2-deep buffer per port.
// Also counts beats delivered on each output port.
module stream_demux_1t2
  import carp_bus_pkg::*;
#(
  parameter int WIDTH = DEF_DATA_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out0_valid,
  output logic [WIDTH-1:0] out0_data,
  input  logic             out0_ready,
  output logic             out1_valid,
  output logic [WIDTH-1:0] out1_data,
  input  logic             out1_ready,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  logic [1:0] sel_oh;
  logic [1:0] push;
  logic       full0;
  logic       full1;
  logic       pop0;
  logic       pop1;
  logic       accept;

  assign sel_oh = port_onehot(port_e'(in_sel));
  // ready depends only on the selected buffer, never on the sinks
  assign in_ready = (port_e'(in_sel) == PORT1) ? !full1 : !full0;
  assign accept   = in_valid && in_ready;
  assign push     = accept ? sel_oh : 2'b00;
  assign pop0     = out0_valid && out0_ready;
  assign pop1     = out1_valid && out1_ready;

  demux_slot_buf #(
    .WIDTH (WIDTH)
  ) u_buf0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push[0]),
    .push_data (in_data),
    .pop       (pop0),
    .full      (full0),
    .valid     (out0_valid),
    .head      (out0_data)
  );

  demux_slot_buf #(
    .WIDTH (WIDTH)
  ) u_buf1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push[1]),
    .push_data (in_data),
    .pop       (pop1),
    .full      (full1),
    .valid     (out1_valid),
    .head      (out1_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else if (clr_cnt) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (pop0) cnt0 <= cnt0 + CNT_W'(1);
      if (pop1) cnt1 <= cnt1 + CNT_W'(1);
    end
  end

endmodule
